// File: rtl/combat_resolver_pkg.sv
// Shared encodings and default tuning for the combat resolver, the player FSMs and the HUD.
package combat_resolver_pkg;

   // Per-player stun state.
   typedef enum logic [1:0] {
      STUN_NONE  = 2'd0,
      STUN_HIT   = 2'd1,
      STUN_BLOCK = 2'd2
   } stun_state_t;

   // Match progress.
   typedef enum logic {
      MATCH_FIGHT = 1'b0,
      MATCH_OVER  = 1'b1
   } match_state_t;

   // Winner codes.
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Default gameplay constants.
   localparam logic [9:0] DEF_HITBOX_W         = 10'd16;
   localparam logic [7:0] DEF_HITSTUN_FRAMES   = 8'd20;
   localparam logic [7:0] DEF_BLOCKSTUN_FRAMES = 8'd10;
   localparam logic [2:0] DEF_HEALTH_MAX       = 3'd3;
   localparam logic [2:0] DEF_HIT_DAMAGE       = 3'd1;

   // Health subtraction that bottoms out at zero.
   function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
      if (a > b) begin
         return a - b;
      end else begin
         return 3'd0;
      end
   endfunction

endpackage

// File: rtl/combat_resolver_stun_timer.sv
// Per-player stun FSM: NONE / HIT / BLOCK with a frame counter.
// A hit always (re)loads hitstun; a block cannot interrupt hitstun.
module stun_timer
   import combat_resolver_pkg::*;
#(
   parameter logic [7:0] HIT_FRAMES   = DEF_HITSTUN_FRAMES,
   parameter logic [7:0] BLOCK_FRAMES = DEF_BLOCKSTUN_FRAMES
) (
   input  logic clk_game,
   input  logic reset,
   input  logic hit_event,
   input  logic block_event,
   output logic in_hitstun,
   output logic in_blockstun
);

   stun_state_t state_r;
   logic [7:0]  count_r;

   // Stun state, counter and registered stun levels.
   always_ff @(posedge clk_game or posedge reset) begin
      if (reset) begin
         state_r      <= STUN_NONE;
         count_r      <= 8'd0;
         in_hitstun   <= 1'b0;
         in_blockstun <= 1'b0;
      end else if (hit_event) begin
         state_r      <= STUN_HIT;
         count_r      <= HIT_FRAMES - 8'd1;
         in_hitstun   <= 1'b1;
         in_blockstun <= 1'b0;
      end else if (block_event && (state_r != STUN_HIT)) begin
         state_r      <= STUN_BLOCK;
         count_r      <= BLOCK_FRAMES - 8'd1;
         in_hitstun   <= 1'b0;
         in_blockstun <= 1'b1;
      end else begin
         case (state_r)
            STUN_HIT, STUN_BLOCK: begin
               if (count_r == 8'd0) begin
                  state_r      <= STUN_NONE;
                  in_hitstun   <= 1'b0;
                  in_blockstun <= 1'b0;
               end else begin
                  count_r <= count_r - 8'd1;
               end
            end
            STUN_NONE: begin
               count_r      <= 8'd0;
               in_hitstun   <= 1'b0;
               in_blockstun <= 1'b0;
            end
            default: begin
               state_r      <= STUN_NONE;
               count_r      <= 8'd0;
               in_hitstun   <= 1'b0;
               in_blockstun <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/combat_resolver.sv
// Combat resolver: range check, hit/block decision, stun timers, health and match end.
// P1 is always left of P2; one shared range decides reach in both directions.
module combat_resolver
   import combat_resolver_pkg::*;
#(
   parameter logic [9:0] HITBOX_W         = DEF_HITBOX_W,
   parameter logic [7:0] HITSTUN_FRAMES   = DEF_HITSTUN_FRAMES,
   parameter logic [7:0] BLOCKSTUN_FRAMES = DEF_BLOCKSTUN_FRAMES,
   parameter logic [2:0] HEALTH_MAX       = DEF_HEALTH_MAX,
   parameter logic [2:0] HIT_DAMAGE       = DEF_HIT_DAMAGE
) (
   input  logic       clk_game,
   input  logic       reset,
   input  logic [9:0] p1_x_pos,
   input  logic [9:0] p1_width,
   input  logic       p1_attack_active,
   input  logic       p1_moving_backward,
   input  logic [9:0] p2_x_pos,
   input  logic [9:0] p2_width,
   input  logic       p2_attack_active,
   input  logic       p2_moving_backward,
   output logic       p1_in_hitstun,
   output logic       p1_in_blockstun,
   output logic       p2_in_hitstun,
   output logic       p2_in_blockstun,
   output logic [2:0] p1_health,
   output logic [2:0] p2_health,
   output logic       game_over,
   output logic [1:0] winner
);

   match_state_t match_r;
   logic         p1_connected_r;
   logic         p2_connected_r;
   logic [11:0]  reach_s;
   logic         in_range_s;
   logic         p1_qualify_s;
   logic         p2_qualify_s;
   logic         p1_hit_s;
   logic         p1_block_s;
   logic         p2_hit_s;
   logic         p2_block_s;

   // Range and event decode; the extra headroom bit keeps the sum from wrapping.
   // p1_hit_s / p1_block_s describe what happens to P1 (attacked by P2).
   always_comb begin
      reach_s      = {2'b00, p1_x_pos} + {2'b00, p1_width} + {2'b00, HITBOX_W};
      in_range_s   = (reach_s > {2'b00, p2_x_pos});
      p1_qualify_s = (match_r == MATCH_FIGHT) && p1_attack_active && !p1_connected_r && in_range_s;
      p2_qualify_s = (match_r == MATCH_FIGHT) && p2_attack_active && !p2_connected_r && in_range_s;
      p2_block_s   = p1_qualify_s && p2_moving_backward && !p2_in_hitstun;
      p2_hit_s     = p1_qualify_s && !p2_block_s;
      p1_block_s   = p2_qualify_s && p1_moving_backward && !p1_in_hitstun;
      p1_hit_s     = p2_qualify_s && !p1_block_s;
   end

   // Connect latches: one event per attack, re-armed when the attack ends.
   always_ff @(posedge clk_game or posedge reset) begin
      if (reset) begin
         p1_connected_r <= 1'b0;
         p2_connected_r <= 1'b0;
      end else begin
         if (!p1_attack_active) begin
            p1_connected_r <= 1'b0;
         end else if (p1_qualify_s) begin
            p1_connected_r <= 1'b1;
         end else begin
            p1_connected_r <= p1_connected_r;
         end
         if (!p2_attack_active) begin
            p2_connected_r <= 1'b0;
         end else if (p2_qualify_s) begin
            p2_connected_r <= 1'b1;
         end else begin
            p2_connected_r <= p2_connected_r;
         end
      end
   end

   // Health bookkeeping and match FSM; events are already gated off in OVER.
   always_ff @(posedge clk_game or posedge reset) begin
      if (reset) begin
         p1_health <= HEALTH_MAX;
         p2_health <= HEALTH_MAX;
         match_r   <= MATCH_FIGHT;
         game_over <= 1'b0;
         winner    <= WIN_NONE;
      end else begin
         if (p1_hit_s) begin
            p1_health <= sat_sub(p1_health, HIT_DAMAGE);
         end else begin
            p1_health <= p1_health;
         end
         if (p2_hit_s) begin
            p2_health <= sat_sub(p2_health, HIT_DAMAGE);
         end else begin
            p2_health <= p2_health;
         end
         case (match_r)
            MATCH_FIGHT: begin
               if ((p1_health == 3'd0) || (p2_health == 3'd0)) begin
                  match_r   <= MATCH_OVER;
                  game_over <= 1'b1;
                  case ({p1_health == 3'd0, p2_health == 3'd0})
                     2'b01:   winner <= WIN_P1;
                     2'b10:   winner <= WIN_P2;
                     2'b11:   winner <= WIN_DRAW;
                     default: winner <= WIN_NONE;
                  endcase
               end else begin
                  match_r <= MATCH_FIGHT;
               end
            end
            MATCH_OVER: begin
               match_r   <= MATCH_OVER;
               game_over <= 1'b1;
            end
            default: begin
               match_r <= MATCH_FIGHT;
            end
         endcase
      end
   end

   stun_timer #(
      .HIT_FRAMES   (HITSTUN_FRAMES),
      .BLOCK_FRAMES (BLOCKSTUN_FRAMES)
   ) u_p1_stun (
      .clk_game     (clk_game),
      .reset        (reset),
      .hit_event    (p1_hit_s),
      .block_event  (p1_block_s),
      .in_hitstun   (p1_in_hitstun),
      .in_blockstun (p1_in_blockstun)
   );

   stun_timer #(
      .HIT_FRAMES   (HITSTUN_FRAMES),
      .BLOCK_FRAMES (BLOCKSTUN_FRAMES)
   ) u_p2_stun (
      .clk_game     (clk_game),
      .reset        (reset),
      .hit_event    (p2_hit_s),
      .block_event  (p2_block_s),
      .in_hitstun   (p2_in_hitstun),
      .in_blockstun (p2_in_blockstun)
   );

endmodule

// File: tb/tb_combat_resolver.sv
// Directed testbench for combat_resolver with hand-computed expectations.
module tb_combat_resolver;

   logic       clk_game = 1'b0;
   logic       reset;
   logic [9:0] p1_x_pos, p1_width, p2_x_pos, p2_width;
   logic       p1_attack_active, p1_moving_backward;
   logic       p2_attack_active, p2_moving_backward;
   logic       p1_in_hitstun, p1_in_blockstun, p2_in_hitstun, p2_in_blockstun;
   logic [2:0] p1_health, p2_health;
   logic       game_over;
   logic [1:0] winner;

   int n_vec  = 0;
   int n_miss = 0;
   int c_p1h, c_p1b, c_p2h, c_p2b;
   logic first_p1h, first_p2h, first_p2b;

   // Free-running game tick.
   always #5 clk_game = ~clk_game;

   combat_resolver dut (
      .clk_game           (clk_game),
      .reset              (reset),
      .p1_x_pos           (p1_x_pos),
      .p1_width           (p1_width),
      .p1_attack_active   (p1_attack_active),
      .p1_moving_backward (p1_moving_backward),
      .p2_x_pos           (p2_x_pos),
      .p2_width           (p2_width),
      .p2_attack_active   (p2_attack_active),
      .p2_moving_backward (p2_moving_backward),
      .p1_in_hitstun      (p1_in_hitstun),
      .p1_in_blockstun    (p1_in_blockstun),
      .p2_in_hitstun      (p2_in_hitstun),
      .p2_in_blockstun    (p2_in_blockstun),
      .p1_health          (p1_health),
      .p2_health          (p2_health),
      .game_over          (game_over),
      .winner             (winner)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_game);
      #1;
   endtask

   // Runs n ticks counting stun samples; attacks are dropped after two ticks high.
   task automatic run(input int n);
      c_p1h = 0; c_p1b = 0; c_p2h = 0; c_p2b = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == 0) begin
            first_p1h = p1_in_hitstun;
            first_p2h = p2_in_hitstun;
            first_p2b = p2_in_blockstun;
         end
         c_p1h += int'(p1_in_hitstun);
         c_p1b += int'(p1_in_blockstun);
         c_p2h += int'(p2_in_hitstun);
         c_p2b += int'(p2_in_blockstun);
         if (i == 1) begin
            p1_attack_active = 1'b0;
            p2_attack_active = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      reset              = 1'b1;
      p1_x_pos           = 10'd100;
      p1_width           = 10'd32;
      p2_x_pos           = 10'd140;
      p2_width           = 10'd32;
      p1_attack_active   = 1'b0;
      p2_attack_active   = 1'b0;
      p1_moving_backward = 1'b0;
      p2_moving_backward = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      do_reset();
      check_vec("rst_p1_hitstun", p1_in_hitstun, 0);
      check_vec("rst_p2_blockstun", p2_in_blockstun, 0);
      check_vec("rst_p1_health", p1_health, 3);
      check_vec("rst_p2_health", p2_health, 3);
      check_vec("rst_game_over", game_over, 0);
      check_vec("rst_winner", winner, 0);

      // Clean hit.
      p1_attack_active = 1'b1;
      run(30);
      check_vec("hit_first_tick", first_p2h, 1);
      check_vec("hit_len", c_p2h, 20);
      check_vec("hit_no_block", c_p2b, 0);
      check_vec("hit_attacker_clean", c_p1h + c_p1b, 0);
      check_vec("hit_p2_health", p2_health, 2);
      check_vec("hit_p1_health", p1_health, 3);

      // Block.
      do_reset();
      p2_moving_backward = 1'b1;
      p1_attack_active   = 1'b1;
      run(30);
      check_vec("blk_first_tick", first_p2b, 1);
      check_vec("blk_len", c_p2b, 10);
      check_vec("blk_no_hit", c_p2h, 0);
      check_vec("blk_health", p2_health, 3);

      // Out of range, and the range edge (reach 148).
      do_reset();
      p2_x_pos = 10'd150;
      p1_attack_active = 1'b1;
      run(25);
      check_vec("oor150_stun", c_p2h + c_p2b + c_p1h + c_p1b, 0);
      check_vec("oor150_health", p2_health, 3);
      p2_x_pos = 10'd148;
      p1_attack_active = 1'b1;
      run(25);
      check_vec("edge148_stun", c_p2h + c_p2b, 0);
      p2_x_pos = 10'd147;
      p1_attack_active = 1'b1;
      run(25);
      check_vec("edge147_hit", c_p2h, 20);
      check_vec("edge147_health", p2_health, 2);

      // Trade.
      do_reset();
      p1_attack_active = 1'b1;
      p2_attack_active = 1'b1;
      run(30);
      check_vec("trade_p1_first", first_p1h, 1);
      check_vec("trade_p2_first", first_p2h, 1);
      check_vec("trade_p1_len", c_p1h, 20);
      check_vec("trade_p1_health", p1_health, 2);
      check_vec("trade_p2_health", p2_health, 2);

      // KO; second hit lands while P2 is in hitstun and holding back.
      do_reset();
      p1_attack_active = 1'b1;
      run(5);
      p2_moving_backward = 1'b1;
      p1_attack_active   = 1'b1;
      run(30);
      check_vec("hitstun_block_denied", c_p2b, 0);
      check_vec("hitstun_reload_len", c_p2h, 20);
      check_vec("ko_health_after2", p2_health, 1);
      check_vec("ko_not_over_yet", game_over, 0);
      p2_moving_backward = 1'b0;
      p1_attack_active   = 1'b1;
      run(30);
      check_vec("ko_p2_health", p2_health, 0);
      check_vec("ko_game_over", game_over, 1);
      check_vec("ko_winner", winner, 1);
      p1_attack_active = 1'b1;
      run(30);
      check_vec("over_no_stun", c_p2h + c_p2b, 0);
      check_vec("over_health_frozen", p2_health, 0);
      check_vec("over_sticky", game_over, 1);

      // Draw by three trades.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         p1_attack_active = 1'b1;
         p2_attack_active = 1'b1;
         run(25);
      end
      check_vec("draw_p1_health", p1_health, 0);
      check_vec("draw_p2_health", p2_health, 0);
      check_vec("draw_winner", winner, 3);

      // Reset in the middle of hitstun.
      do_reset();
      p1_attack_active = 1'b1;
      run(5);
      check_vec("mid_stun_active", p2_in_hitstun, 1);
      reset = 1'b1;
      #1;
      check_vec("mid_rst_hitstun", p2_in_hitstun, 0);
      check_vec("mid_rst_health", p2_health, 3);
      check_vec("mid_rst_game_over", game_over, 0);
      tick();
      reset = 1'b0;
      tick();
      p1_attack_active = 1'b1;
      run(30);
      check_vec("post_rst_hit_len", c_p2h, 20);
      check_vec("post_rst_health", p2_health, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
